spi_arbiter: RTL

SPI_ARBITER -- requirements
Module: spi_arbiter

---
 rtl/spi_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/spi_arbiter.sv
// Round-robin arbiter that lets NUM_REQ requesters share one SPI engine.
// It issues one byte per transfer, then returns the received byte with a done pulse, or an err pulse on timeout.
module spi_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*8-1:0]   req_data,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     done,
    output logic [NUM_REQ-1:0]     err,
    output logic [7:0]             rdata,
    output logic [7:0]             spi_data_in,
    output logic                   spi_ready_send,
    input  logic                   spi_busy,
    input  logic [7:0]             spi_data_out
);

    localparam int unsigned IW = $clog2(NUM_REQ);
    localparam int unsigned CW = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } state_t;

    state_t               state, state_n;
    logic [IW-1:0]        ptr, ptr_n;
    logic [IW-1:0]        own, own_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [NUM_REQ-1:0]   grant_n, done_n, err_n;
    logic [7:0]           rdata_n, spi_data_in_n;
    logic                 spi_ready_send_n;

    logic                 win_found;
    int unsigned          win_sel;
    int unsigned          cand;

    // Round-robin search starting just above the last owner, wrapping modulo NUM_REQ
    always_comb begin
        win_found = 1'b0;
        win_sel   = 0;
        cand      = 0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = (32'(ptr) + i) % NUM_REQ;
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_sel   = cand;
            end
        end
    end

    always_comb begin
        state_n          = state;
        ptr_n            = ptr;
        own_n            = own;
        cnt_n            = cnt;
        grant_n          = grant;
        done_n           = '0;
        err_n            = '0;
        rdata_n          = rdata;
        spi_data_in_n    = spi_data_in;
        spi_ready_send_n = spi_ready_send;

        case (state)
            IDLE: begin
                if (win_found && !spi_busy) begin
                    own_n            = IW'(win_sel);
                    grant_n          = NUM_REQ'(1) << win_sel;
                    spi_data_in_n    = req_data[8*win_sel +: 8];
                    spi_ready_send_n = 1'b1;
                    cnt_n            = '0;
                    state_n          = ISSUE;
                end
            end
            ISSUE: begin
                if (spi_busy) begin
                    spi_ready_send_n = 1'b0;
                    state_n          = BUSY;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    spi_ready_send_n = 1'b0;
                    grant_n          = '0;
                    err_n            = grant;
                    ptr_n            = own;
                    state_n          = IDLE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            BUSY: begin
                if (!spi_busy) begin
                    rdata_n = spi_data_out;
                    done_n  = grant;
                    grant_n = '0;
                    ptr_n   = own;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n          = IDLE;
                grant_n          = '0;
                spi_ready_send_n = 1'b0;
            end
        endcase
    end

    // Reset parks ptr on the last index so requester 0 wins first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            ptr            <= IW'(NUM_REQ - 1);
            own            <= '0;
            cnt            <= '0;
            grant          <= '0;
            done           <= '0;
            err            <= '0;
            rdata          <= '0;
            spi_data_in    <= '0;
            spi_ready_send <= 1'b0;
        end else begin
            state          <= state_n;
            ptr            <= ptr_n;
            own            <= own_n;
            cnt            <= cnt_n;
            grant          <= grant_n;
            done           <= done_n;
            err            <= err_n;
            rdata          <= rdata_n;
            spi_data_in    <= spi_data_in_n;
            spi_ready_send <= spi_ready_send_n;
        end
    end

endmodule
